alt_ddrx_reset_sequencer: RTL and testbench

- Generates the controller's raw reset requests, `ctl_half_clk_reset_n` and `ctl_reset_n`, from PLL lock status and a software reset handshake.
- Drives the inputs of the per-domain reset synchronizers in the clock-and-reset block.
- Holds both resets asserted for a minimum time and waits for stable PLL lock.
- Releases the half-rate reset first, then the full-rate reset after a programmable gap.
- Services soft-reset requests with a 4-phase req/ack handshake.

---
 rtl/alt_ddrx_reset_sequencer_pkg.sv | 15 +
 rtl/alt_ddrx_lock_sync.sv | 25 ++
 rtl/alt_ddrx_reset_sequencer.sv | 140 ++++++++++++++
 tb/tb_alt_ddrx_reset_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alt_ddrx_reset_sequencer_pkg.sv
// Shared definitions for the DDRx controller reset sequencer: state encoding
// and the default counter width.
package alt_ddrx_reset_sequencer_pkg;

  localparam int CNT_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_REL_HALF  = 3'd2,
    ST_RUN       = 3'd3,
    ST_SOFT      = 3'd4
  } rst_state_e;

endpackage

// File: rtl/alt_ddrx_lock_sync.sv
// Multi-flop level synchronizer for the asynchronous PLL lock indication,
// cleared asynchronously so lock is never reported during reset.
module alt_ddrx_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/alt_ddrx_reset_sequencer.sv
// Sequences the controller's half-rate and full-rate raw resets from PLL lock
// and a soft-reset req/ack handshake; every output is a flop.
import alt_ddrx_reset_sequencer_pkg::*;

module alt_ddrx_reset_sequencer #(
  parameter int LOCK_SYNC_STAGES   = 2,
  parameter int MIN_ASSERT_CYCLES  = 8,
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int RELEASE_GAP_CYCLES = 4,
  parameter int CNT_WIDTH          = CNT_WIDTH_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       soft_reset_ack,
  output logic       ctl_half_clk_reset_n,
  output logic       ctl_reset_n,
  output logic       reset_done,
  output logic [2:0] state_dbg
);

  localparam logic [CNT_WIDTH-1:0] ASSERT_LAST = CNT_WIDTH'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST    = CNT_WIDTH'(RELEASE_GAP_CYCLES - 1);

  rst_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ack_q, ack_d;
  logic                 half_q, half_d;
  logic                 full_q, full_d;
  logic                 done_q, done_d;
  logic                 lock_s;

  alt_ddrx_lock_sync #(
    .STAGES (LOCK_SYNC_STAGES)
  ) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (pll_locked),
    .q_o     (lock_s)
  );

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_ASSERT: begin
        if (cnt_q == ASSERT_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_REL_HALF;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_REL_HALF: begin
        if (!lock_s) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        // Lock loss takes priority; a held request is picked up on the next RUN.
        if (!lock_s) begin
          state_d = ST_ASSERT;
        end else if (soft_reset_req) begin
          state_d = ST_SOFT;
        end
      end
      ST_SOFT: begin
        if (ack_q) begin
          ack_d = 1'b1;
          if (!soft_reset_req) begin
            ack_d   = 1'b0;
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end else if (cnt_q == ASSERT_LAST) begin
          ack_d = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
      end
    endcase

    half_d = (state_d == ST_REL_HALF) || (state_d == ST_RUN);
    full_d = (state_d == ST_RUN);
    done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      half_q  <= 1'b0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      half_q  <= half_d;
      full_q  <= full_d;
      done_q  <= done_d;
    end
  end

  assign soft_reset_ack       = ack_q;
  assign ctl_half_clk_reset_n = half_q;
  assign ctl_reset_n          = full_q;
  assign reset_done           = done_q;
  assign state_dbg            = state_q;

endmodule

// File: tb/tb_alt_ddrx_reset_sequencer.sv
// Directed bench for the reset sequencer: a vector table for the main flow
// plus hand-written sequences for lock timing, early drop and async reset.
module tb_alt_ddrx_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_reset_req = 1'b0;
  logic       soft_reset_ack;
  logic       ctl_half_clk_reset_n;
  logic       ctl_reset_n;
  logic       reset_done;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int cur_edge = 0;

  alt_ddrx_reset_sequencer dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .pll_locked           (pll_locked),
    .soft_reset_req       (soft_reset_req),
    .soft_reset_ack       (soft_reset_ack),
    .ctl_half_clk_reset_n (ctl_half_clk_reset_n),
    .ctl_reset_n          (ctl_reset_n),
    .reset_done           (reset_done),
    .state_dbg            (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic       pll;
    logic       req;
    logic [2:0] st;
    logic       half;
    logic       full;
    logic       done;
    logic       ack;
  } vec_t;

  vec_t vecs[27];

  task automatic tick();
    @(posedge clk);
    #1;
    cur_edge++;
  endtask

  task automatic run_to(input int n);
    while (cur_edge < n) tick();
  endtask

  task automatic check(input string name, input logic [2:0] st, input logic half,
                       input logic full, input logic done, input logic ack);
    logic [6:0] got, exp;
    got = {state_dbg, ctl_half_clk_reset_n, ctl_reset_n, reset_done, soft_reset_ack};
    exp = {st, half, full, done, ack};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d half=%b full=%b done=%b ack=%b, expected st=%0d half=%b full=%b done=%b ack=%b",
               name, got[6:4], got[3], got[2], got[1], got[0],
               exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end else begin
      $display("ok   %s: st=%0d half=%b full=%b done=%b ack=%b", name,
               got[6:4], got[3], got[2], got[1], got[0]);
    end
  endtask

  // Hold reset for a few cycles, then release on a falling edge so the next
  // rising edge is edge 1 of the sequence.
  task automatic do_reset(input logic pll);
    reset_n        = 1'b0;
    pll_locked     = pll;
    soft_reset_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n  = 1'b1;
    cur_edge = 0;
  endtask

  initial begin
    // Power-up, soft reset, then simultaneous lock loss and request.
    vecs[0]  = '{0,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{7,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8,  1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{23, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{24, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{27, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{28, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{30, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{31, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{38, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{39, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{42, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{43, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{58, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{59, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{62, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{63, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{64, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[18] = '{66, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[19] = '{67, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{75, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{91, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{95, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[23] = '{96, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[24] = '{103, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[25] = '{104, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[26] = '{105, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};

    do_reset(1'b1);
    for (int i = 0; i < 27; i++) begin
      pll_locked     = vecs[i].pll;
      soft_reset_req = vecs[i].req;
      run_to(vecs[i].edge_no);
      check($sformatf("vec%0d@edge%0d", i, vecs[i].edge_no), vecs[i].st,
            vecs[i].half, vecs[i].full, vecs[i].done, vecs[i].ack);
    end

    // Late lock: input rises after edge 40, half release 18 edges later.
    do_reset(1'b0);
    run_to(40);
    check("late_lock_wait@40", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    pll_locked = 1'b1;
    run_to(57);
    check("late_lock@57", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_to(58);
    check("late_lock@58", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    // One-cycle lock glitch at count 10 pushes release from edge 24 to 37.
    do_reset(1'b1);
    run_to(18);
    pll_locked = 1'b0;
    run_to(19);
    pll_locked = 1'b1;
    run_to(24);
    check("glitch_no_rel@24", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_to(36);
    check("glitch@36", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_to(37);
    check("glitch@37", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Request dropped before ack: full hold, one-cycle ack, then WAIT_LOCK.
    do_reset(1'b1);
    run_to(28);
    check("early_run@28", 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    soft_reset_req = 1'b1;
    run_to(30);
    soft_reset_req = 1'b0;
    run_to(36);
    check("early_drop@36", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    run_to(37);
    check("early_drop_ack@37", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    run_to(38);
    check("early_drop_exit@38", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset pulse in REL_HALF clears outputs without a clock edge.
    do_reset(1'b1);
    run_to(25);
    check("async_pre@25", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("async_clear", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n  = 1'b1;
    cur_edge = 0;
    run_to(23);
    check("async_rerun@23", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_to(24);
    check("async_rerun@24", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    run_to(28);
    check("async_rerun@28", 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
